// File: rtl/multi_input_pkg.sv
// Shared sizing helpers for the multi-input adder front end, its packer and bench.
package multi_input_pkg;

  localparam int NUM_INPUT_DFLT    = 45;
  localparam int WIDTH_IN_DFLT     = 16;
  localparam int OUTPUT_DELAY_DFLT = 5;

  // Counter width able to hold 0..num_input inclusive.
  function automatic int cnt_w(input int num_input);
    return $clog2(num_input + 1);
  endfunction

  // Adder result width: enough headroom for num_input full-scale samples.
  function automatic int width_out(input int width_in, input int num_input);
    return width_in + $clog2(num_input);
  endfunction

  localparam int CNT_W     = cnt_w(NUM_INPUT_DFLT);
  localparam int WIDTH_OUT = width_out(WIDTH_IN_DFLT, NUM_INPUT_DFLT);

endpackage

// File: rtl/multi_input_packer_if.sv
// Sample stream in, packed frame out; slave is the packer, master is the producer/consumer side.
interface multi_input_packer_if
  import multi_input_pkg::*;
#(
  parameter int NUM_INPUT = NUM_INPUT_DFLT,
  parameter int WIDTH_IN  = WIDTH_IN_DFLT
);
  localparam int FILL_W = cnt_w(NUM_INPUT);

  logic                                s_valid;
  logic                                s_ready;
  logic [WIDTH_IN-1:0]                 s_data;
  logic                                flush;
  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din;
  logic                                din_valid;
  logic                                sum_valid;
  logic [FILL_W-1:0]                   fill_count;

  modport master (
    output s_valid, s_data, flush,
    input  s_ready, din, din_valid, sum_valid, fill_count
  );

  modport slave (
    input  s_valid, s_data, flush,
    output s_ready, din, din_valid, sum_valid, fill_count
  );
endinterface

// File: rtl/valid_delay_line.sv
// Enable-gated strobe delay: out is in delayed by DEPTH enabled clock edges.
module valid_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic in,
  output logic out
);
  logic [DEPTH-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (ena) begin
      shift_d[0] = in;
      for (int i = 1; i < DEPTH; i++) shift_d[i] = shift_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_q <= '0;
    else     shift_q <= shift_d;
  end

  assign out = shift_q[DEPTH-1];
endmodule

// File: rtl/multi_input_packer.sv
// Packs NUM_INPUT stream samples into a double-buffered parallel frame for the adder,
// with a sum_valid strobe aligned to the adder's fixed latency.
module multi_input_packer
  import multi_input_pkg::*;
#(
  parameter int NUM_INPUT    = NUM_INPUT_DFLT,
  parameter int WIDTH_IN     = WIDTH_IN_DFLT,
  parameter int OUTPUT_DELAY = OUTPUT_DELAY_DFLT
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 ena,
  multi_input_packer_if.slave bus
);
  localparam int IDX_W = cnt_w(NUM_INPUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUT - 1);

  typedef logic [NUM_INPUT-1:0][WIDTH_IN-1:0] frame_t;

  frame_t            fill_q, fill_d;
  frame_t            din_q, din_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              din_valid_q, din_valid_d;
  logic              beat, emit;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    fill_d      = fill_q;
    din_d       = din_q;
    idx_d       = idx_q;
    din_valid_d = din_valid_q;

    beat = ena && bus.s_valid;
    // A flush that lands on the completing beat is just a normal completion.
    emit = (beat && idx_q == LAST_IDX) ||
           (ena && bus.flush && (idx_q != '0 || beat));

    if (beat) fill_d[idx_q] = bus.s_data;

    if (emit) begin
      // Unfilled slots go to zero: the additive identity for signed or unsigned sums.
      for (int k = 0; k < NUM_INPUT; k++) begin
        if (k < int'(idx_q))                  din_d[k] = fill_q[k];
        else if (k == int'(idx_q) && beat)    din_d[k] = bus.s_data;
        else                                  din_d[k] = '0;
      end
      idx_d = '0;
    end else if (beat) begin
      idx_d = idx_q + IDX_W'(1);
    end

    if (ena) din_valid_d = emit;
  end

  // NOTE: the fill buffer is never read beyond idx, so it carries no reset.
  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      din_q       <= '0;
      idx_q       <= '0;
      din_valid_q <= 1'b0;
    end else begin
      din_q       <= din_d;
      idx_q       <= idx_d;
      din_valid_q <= din_valid_d;
    end
  end

  valid_delay_line #(.DEPTH(OUTPUT_DELAY)) u_sum_delay (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .in  (din_valid_q),
    .out (bus.sum_valid)
  );

  assign bus.s_ready    = ena;
  assign bus.din        = din_q;
  assign bus.din_valid  = din_valid_q;
  assign bus.fill_count = idx_q;
endmodule

// File: tb/tb_multi_input_packer.sv
// Scoreboard bench for multi_input_packer: a frame model pushes expected frames and
// sum_valid edge numbers; DUT strobes pop and compare them.
module tb_multi_input_packer;
  import multi_input_pkg::*;

  localparam int N = 45;
  localparam int W = 16;
  localparam int D = 5;
  localparam int WO = width_out(W, N);

  typedef logic [N-1:0][W-1:0] frame_t;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  always #5 clk = ~clk;

  multi_input_packer_if #(.NUM_INPUT(N), .WIDTH_IN(W)) bus ();

  multi_input_packer #(.NUM_INPUT(N), .WIDTH_IN(W), .OUTPUT_DELAY(D)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  frame_t m_fill;
  int     m_idx = 0;
  int     edge_n = 0;
  frame_t frame_q[$];
  int     sum_q[$];
  frame_t last_frame = '0;
  logic   exp_dv = 1'b0;
  logic   exp_sv = 1'b0;

  // One clock cycle of stimulus; model updates, then outputs are sampled 1 ns after the edge.
  task automatic step(input logic e, input logic v, input logic [W-1:0] d, input logic f);
    logic beat, emit;
    frame_t fr;
    ena         = e;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.flush   = f;
    beat = e && v;
    emit = 1'b0;
    if (e) begin
      if (beat) m_fill[m_idx] = d;
      if ((beat && m_idx == N-1) || (f && (m_idx > 0 || beat))) emit = 1'b1;
      if (emit) begin
        fr = '0;
        for (int k = 0; k < (beat ? m_idx + 1 : m_idx); k++) fr[k] = m_fill[k];
        frame_q.push_back(fr);
        sum_q.push_back(edge_n + 1 + D);
        m_idx = 0;
      end else if (beat) begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    if (e) begin
      edge_n++;
      exp_dv = emit;
      exp_sv = (sum_q.size() > 0 && sum_q[0] == edge_n);
      if (exp_sv) void'(sum_q.pop_front());
      if (bus.din_valid && frame_q.size() > 0) last_frame = frame_q.pop_front();
    end
    check("s_ready", bus.s_ready, e);
    check("fill_count", bus.fill_count, m_idx);
    check("din_valid", bus.din_valid, exp_dv);
    check("sum_valid", bus.sum_valid, exp_sv);
    check("din", bus.din, last_frame);
  endtask

  task automatic beats(input int count, input int base);
    for (int i = 0; i < count; i++) step(1'b1, 1'b1, W'(base + i), 1'b0);
  endtask

  task automatic idle(input int count);
    for (int i = 0; i < count; i++) step(1'b1, 1'b0, '0, 1'b0);
  endtask

  logic [WO-1:0] acc;

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.flush   = 1'b0;
    #12;
    check("rst_fill_count", bus.fill_count, 0);
    check("rst_din", bus.din, 0);
    check("rst_din_valid", bus.din_valid, 0);
    check("rst_sum_valid", bus.sum_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full frame of 1..45; the adder would see 1035
    beats(N, 1);
    idle(D + 1);
    acc = '0;
    for (int k = 0; k < N; k++) acc += WO'(bus.din[k]);
    check("dout_sum", acc, 1035);

    // ena gaps mid-frame (valid held high, must not be accepted) and with sum in flight
    beats(10, 100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hdead, 1'b0);
    beats(N - 10, 110);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    idle(D);

    // Back-to-back frames at full rate
    for (int i = 0; i < 3 * N; i++) step(1'b1, 1'b1, W'($urandom), 1'b0);
    idle(D + 1);

    // Partial flush, ignored flush, flush with the completing beat
    step(1'b1, 1'b1, 16'd7, 1'b0);
    step(1'b1, 1'b1, 16'd9, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 16'd55, 1'b1);
    beats(N - 1, 1);
    step(1'b1, 1'b1, W'(N), 1'b1);
    idle(D + 1);

    // Reset with a partial frame and a strobe in the delay line
    beats(19, 300);
    step(1'b1, 1'b1, 16'd319, 1'b1);
    beats(2, 400);
    #2;
    rst = 1'b1;
    #1;
    check("arst_fill_count", bus.fill_count, 0);
    check("arst_din", bus.din, 0);
    check("arst_sum_valid", bus.sum_valid, 0);
    m_idx = 0;
    frame_q.delete();
    sum_q.delete();
    last_frame = '0;
    exp_dv = 1'b0;
    exp_sv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(D + 3);
    beats(N, 500);
    idle(D + 1);

    check("frames_left", frame_q.size(), 0);
    check("sums_left", sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
